// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and a data-memory target (slave).
// Handshake: a request (memread or memwrite) is held by the master while busy=1; it is
// taken at the edge ending the first busy cycle, and completion is a one-cycle rvalid/wdone pulse.
interface dmem_responder_if;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        wdone;
    logic        busy;
    logic        err;

    modport master (
        output memread, memwrite, addr, wdata,
        input  rdata, rvalid, wdone, busy, err
    );

    modport slave (
        input  memread, memwrite, addr, wdata,
        output rdata, rvalid, wdone, busy, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-wide data-memory target with a programmable number of wait states.
// Holds the pipeline via busy until the single response cycle.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              op_wr;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              rvalid_q;
    logic              wdone_q;
    logic              err_q;
    logic [31:0]       mem [2**ADDR_W];

    logic              req;
    logic              bad_req;
    logic              ok_req;
    logic              access;
    logic              acc_wr;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata;
    logic              unused_addr_hi;

    // Upper address bits only select beyond the array; the index wraps.
    assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

    always_comb begin
        req       = bus.memread | bus.memwrite;
        bad_req   = (bus.memread & bus.memwrite) | (bus.addr[1:0] != 2'b00);
        ok_req    = req & ~bad_req;
        access    = 1'b0;
        acc_wr    = op_wr;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        if (state == S_WAIT && cnt == 4'd0) begin
            access = 1'b1;
        end else if (ZERO_WAIT && state == S_IDLE && ok_req) begin
            // With no wait states the array is touched on the accepting edge itself.
            access    = 1'b1;
            acc_wr    = bus.memwrite;
            acc_idx   = bus.addr[ADDR_W+1:2];
            acc_wdata = bus.wdata;
        end
        bus.busy = reset & ((state == S_WAIT) | ((state == S_IDLE) & ok_req));
    end

    // Array has no reset; gating with reset drops any store still in flight.
    always_ff @(posedge clk) begin
        if (reset && access && acc_wr) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            op_wr    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req && bad_req) begin
                        err_q <= 1'b1;
                    end else if (ok_req) begin
                        op_wr   <= bus.memwrite;
                        idx_q   <= bus.addr[ADDR_W+1:2];
                        wdata_q <= bus.wdata;
                        cnt     <= CNT_INIT;
                        state   <= ZERO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (access) begin
                if (acc_wr) begin
                    wdone_q <= 1'b1;
                end else begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= mem[acc_idx];
                end
            end
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.wdone  = wdone_q;
    assign bus.err    = err_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with two wait states, one with none, sharing clock and reset.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_responder_if ia ();
    dmem_responder_if ib ();
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (ia.slave),
        .dbg_state (dbg_a)
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (ib.slave),
        .dbg_state (dbg_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_a();
        ia.memread  = 1'b0;
        ia.memwrite = 1'b0;
        ia.addr     = $urandom;
        ia.wdata    = $urandom;
    endtask

    task automatic idle_b();
        ib.memread  = 1'b0;
        ib.memwrite = 1'b0;
        ib.addr     = $urandom;
        ib.wdata    = $urandom;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic txn_a(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd);
        ia.memread  = rd;
        ia.memwrite = wr;
        ia.addr     = a;
        ia.wdata    = wd;
        if (rd && !wr && !exp_err) exp_q.push_back(exp_rd);
        @(negedge clk);
        check({tag, ".busy_c0"}, 32'(ia.busy), 32'(!exp_err));
        @(posedge clk); #1;
        idle_a();
        if (exp_err) begin
            @(negedge clk);
            check({tag, ".err"}, 32'(ia.err), 32'd1);
            check({tag, ".busy_err"}, 32'(ia.busy), 32'd0);
            check({tag, ".resp_err"}, 32'({ia.rvalid, ia.wdone}), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, ".after_err"}, 32'({ia.rvalid, ia.wdone, ia.err}), 32'd0);
            @(posedge clk); #1;
        end else begin
            for (int c = 1; c <= 2; c++) begin
                @(negedge clk);
                check({tag, ".busy_wait"}, 32'(ia.busy), 32'd1);
                check({tag, ".state_wait"}, 32'(dbg_a), 32'd1);
                check({tag, ".early_resp"}, 32'({ia.rvalid, ia.wdone, ia.err}), 32'd0);
                @(posedge clk); #1;
            end
            @(negedge clk);
            check({tag, ".busy_resp"}, 32'(ia.busy), 32'd0);
            check({tag, ".rvalid"}, 32'(ia.rvalid), 32'(rd));
            check({tag, ".wdone"}, 32'(ia.wdone), 32'(wr));
            if (ia.rvalid && exp_q.size() > 0) check({tag, ".rdata"}, ia.rdata, exp_q.pop_front());
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, ".pulse_end"}, 32'({ia.rvalid, ia.wdone, ia.err}), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    // Zero-wait target: response in the next cycle, next request may follow immediately.
    task automatic txn_b(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
        ib.memread  = rd;
        ib.memwrite = wr;
        ib.addr     = a;
        ib.wdata    = wd;
        @(negedge clk);
        check({tag, ".busy_c0"}, 32'(ib.busy), 32'd1);
        @(posedge clk); #1;
        idle_b();
        @(negedge clk);
        check({tag, ".busy_c1"}, 32'(ib.busy), 32'd0);
        check({tag, ".rvalid"}, 32'(ib.rvalid), 32'(rd));
        check({tag, ".wdone"}, 32'(ib.wdone), 32'(wr));
        if (rd) check({tag, ".rdata"}, ib.rdata, exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_a();
        idle_b();
        #2;
        check("rst.rdata", ia.rdata, 32'd0);
        check("rst.pulses", 32'({ia.rvalid, ia.wdone, ia.err, ia.busy}), 32'd0);
        check("rst.state", 32'(dbg_a), 32'd0);
        check("rst.b_pulses", 32'({ib.rvalid, ib.wdone, ib.err, ib.busy}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        txn_a("st10",   1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0);
        txn_a("ld10",   1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
        txn_a("mis13",  1'b1, 1'b0, 32'h13,  32'h0,        1'b1, 32'h0);
        txn_a("ld10b",  1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
        txn_a("st20",   1'b0, 1'b1, 32'h20,  32'h0BADF00D, 1'b0, 32'h0);
        txn_a("both20", 1'b1, 1'b1, 32'h20,  32'h12345678, 1'b1, 32'h0);
        txn_a("mis22",  1'b0, 1'b1, 32'h22,  32'h87654321, 1'b1, 32'h0);
        txn_a("ld20",   1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 32'h0BADF00D);
        txn_a("st404",  1'b0, 1'b1, 32'h404, 32'hA5A5A5A5, 1'b0, 32'h0);
        txn_a("ld004",  1'b1, 1'b0, 32'h004, 32'h0,        1'b0, 32'hA5A5A5A5);
        @(negedge clk);
        check("rdata_hold", ia.rdata, 32'hA5A5A5A5);
        @(posedge clk); #1;

        // Store abandoned by reset during its wait states.
        txn_a("st30pre", 1'b0, 1'b1, 32'h30, 32'h77777777, 1'b0, 32'h0);
        ia.memwrite = 1'b1;
        ia.addr     = 32'h30;
        ia.wdata    = 32'h11111111;
        @(posedge clk); #1;
        idle_a();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.outs", 32'({ia.rvalid, ia.wdone, ia.err, ia.busy}), 32'd0);
        check("rst_mid.state", 32'(dbg_a), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_mid.no_wdone", 32'(ia.wdone), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn_a("ld30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h77777777);

        txn_b("b_st08",  1'b0, 1'b1, 32'h08, 32'hCAFEF00D, 32'h0);
        txn_b("b_ld08",  1'b1, 1'b0, 32'h08, 32'h0,        32'hCAFEF00D);
        txn_b("b_st0c",  1'b0, 1'b1, 32'h0C, 32'h5A5A0001, 32'h0);
        txn_b("b_ld0c",  1'b1, 1'b0, 32'h0C, 32'h0,        32'h5A5A0001);
        txn_b("b_ld08b", 1'b1, 1'b0, 32'h08, 32'h0,        32'hCAFEF00D);

        check("exp_q.empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
